route_sequencer: RTL and testbench
==================================

# route_sequencer

Parametrised route record/playback controller for the navigation datapath. In record mode it run-length encodes the steering direction stream into (direction, duration) segments in an external synchronous RAM. In playback mode it replays the segments in order; in rewind mode it replays them last-to-first with each direction inverted, driving the car back to its start point. It sits between the direction decoder and the motor command mux, and supersedes the fixed-width two-mode control unit.

## Interface
Parameters:
- DIR_W, 3: direction code width
- CNT_W, 14: segment duration counter width
- ADDR_W, 10: RAM address width; depth = 2^ADDR_W segments

Ports:
- Clock  in  1  system clock
- Reset  in  1  synchronous, active-high
- Mode  in  2  0 idle, 1 record, 2 play, 3 rewind
- Tick  in  1  duration time base; one pulse = one duration unit
- InputDirection  in  DIR_W  live direction while recording
- MemRdData  in  DIR_W+CNT_W  RAM read word {dir, count}, valid 1 cycle after MemAddr
- MemAddr  out  ADDR_W  RAM address
- MemWrData  out  DIR_W+CNT_W  {dir, count}
- MemWrite  out  1  RAM write strobe
- CmdDirection  out  DIR_W  direction command during play/rewind, else NONE
- Busy  out  1  record, play or rewind in progress
- Done  out  1  playback/rewind finished; holds until Mode returns to 0
- Full  out  1  RAM full; sticky until the next record start
- Length  out  ADDR_W+1  number of stored segments

## Operation
- States: IDLE, REC, FLUSH, FETCH, RUN, DONE.
- IDLE: Mode 1 -> REC with WrPtr=0, SegCnt=0, HeldDir=InputDirection, Full=0. Mode 2 -> FETCH at addr 0. Mode 3 -> FETCH at addr Length-1. If Length=0, Mode 2/3 go directly to DONE.
- REC:
  - Tick with InputDirection==HeldDir increments SegCnt.
  - InputDirection!=HeldDir writes {HeldDir,SegCnt} at WrPtr and increments WrPtr. HeldDir then takes the new direction and SegCnt becomes Tick?1:0, so a coincident tick counts toward the new segment.
  - Tick with SegCnt at max and the same direction writes {HeldDir,max} and sets SegCnt=1.
  - A write with WrPtr==depth-1 stores the word and sets Full; the pointer stops incrementing. Later writes are dropped and Full stays set.
  - Mode!=1 -> FLUSH.
- FLUSH: one cycle. Writes the final segment if SegCnt!=0 and not Full, then sets Length=WrPtr (plus 1 if written). Next state IDLE.
- FETCH: one cycle for RAM latency; the next cycle loads Dir and Remaining from MemRdData and enters RUN.
- RUN:
  - CmdDirection=Dir, or inv(Dir) in rewind.
  - Each Tick decrements Remaining. The Tick that makes Remaining 0 advances the address: +1 in play, -1 in rewind.
  - When the last segment completes (index Length-1 in play, index 0 in rewind), the FSM enters DONE.
  - A segment stored with count 0 is skipped in one FETCH.
- inv(): FWD<->BACK, LEFT<->RIGHT, NONE->NONE.
- DONE: CmdDirection=NONE, Done=1. Mode 0 -> IDLE.
- Mode change mid-play/rewind -> IDLE the next cycle, CmdDirection=NONE. Length is preserved.
- Mode change to 2/3 during REC passes through FLUSH, then IDLE, then FETCH.

## Timing
- Reset values: state IDLE, MemAddr 0, MemWrite 0, MemWrData 0, CmdDirection NONE, Busy 0, Done 0, Full 0, Length 0. RAM contents are not cleared.
- MemWrite is a single-cycle pulse, registered. MemAddr and MemWrData are valid in the same cycle.
- Record-to-write latency: a direction change at cycle N produces MemWrite at N+1.
- Play start: Mode=2 sampled at cycle N; MemAddr is valid at N+1; CmdDirection is valid at N+3.
- Segment boundary: a decrement to zero at cycle N gives the new CmdDirection at N+3. The old direction holds during the fetch.
- Length is stored in ADDR_W+1 bits, so a full RAM reads as 2^ADDR_W.

## Structure
- Shared package route_pkg: direction codes DIR_NONE=0, DIR_FWD=1, DIR_BACK=2, DIR_LEFT=3, DIR_RIGHT=4; mode encodings; state encoding; function inv_dir.
- Sub-module seg_counter: loadable up/down CNT_W counter with saturate and zero flags. It serves as SegCnt in record and as Remaining in play.
- The RAM stays external.

## Test plan
- Record FWD for 5 ticks, then LEFT for 3 ticks, then Mode 0 -> words {1,5}@0 and {3,3}@1 written; Length=2.
- Play that route -> CmdDirection FWD for 5 ticks, then LEFT for 3 ticks, then Done=1 with NONE.
- Rewind that route -> RIGHT for 3 ticks, then BACK for 5 ticks, then Done=1.
- CNT_W=4, hold FWD for 20 ticks -> words {1,15}, {1,5}; playback yields 20 FWD ticks with no glitch beyond the fetch gap.
- ADDR_W=2, record 6 direction changes -> 4 words written, Full=1, Length=4, 5th write dropped.
- Mode to 0 mid-RUN -> CmdDirection=NONE the next cycle; Length unchanged. Play with Length=0 -> Done on the cycle after the start.

Source files
------------

// File: rtl/route_pkg.sv
// route_pkg: shared constants for the route record/playback controller.
//   - direction codes as produced by the direction decoder
//   - Mode input encodings
//   - controller state encoding (plain constants for legacy tools)
//   - inv_dir(): maps a direction to the one that undoes it
package route_pkg;

  localparam int DIR_NONE  = 0;
  localparam int DIR_FWD   = 1;
  localparam int DIR_BACK  = 2;
  localparam int DIR_LEFT  = 3;
  localparam int DIR_RIGHT = 4;

  localparam logic [1:0] MODE_IDLE = 2'd0;
  localparam logic [1:0] MODE_REC  = 2'd1;
  localparam logic [1:0] MODE_PLAY = 2'd2;
  localparam logic [1:0] MODE_REW  = 2'd3;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_REC   = 3'd1;
  localparam logic [2:0] ST_FLUSH = 3'd2;
  localparam logic [2:0] ST_FETCH = 3'd3;
  localparam logic [2:0] ST_RUN   = 3'd4;
  localparam logic [2:0] ST_DONE  = 3'd5;

  // Unknown codes pass through unchanged so a stray code never turns into motion.
  function automatic logic [31:0] inv_dir(input logic [31:0] d);
    case (d)
      32'(DIR_FWD):   return 32'(DIR_BACK);
      32'(DIR_BACK):  return 32'(DIR_FWD);
      32'(DIR_LEFT):  return 32'(DIR_RIGHT);
      32'(DIR_RIGHT): return 32'(DIR_LEFT);
      default:        return d;
    endcase
  endfunction

endpackage

// File: rtl/seg_counter.sv
// seg_counter: loadable up/down counter shared between the segment
// duration count (record) and the remaining-ticks count (playback).
// Ports:
//   Clock, Reset   clock, synchronous active-high reset (count -> 0)
//   load/load_val  load a new value (highest priority)
//   inc            count up, holds at all-ones
//   dec            count down, holds at zero
//   count          current value
//   zero / sat     count is zero / count is all-ones
module seg_counter
  import route_pkg::*;
#(
  parameter int CNT_W = 14
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             inc,
  input  logic             dec,
  output logic [CNT_W-1:0] count,
  output logic             zero,
  output logic             sat
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  assign zero  = (count_q == '0);
  assign sat   = (count_q == '1);
  assign count = count_q;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (inc && !sat) begin
      count_d = count_q + CNT_W'(1);
    end else if (dec && !zero) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/route_sequencer.sv
// route_sequencer: records the steering direction stream as run-length
// (direction, duration) segments in an external synchronous RAM and replays
// them forwards (play) or backwards with inverted directions (rewind).
// Ports:
//   Clock, Reset    system clock, synchronous active-high reset
//   Mode            0 idle, 1 record, 2 play, 3 rewind
//   Tick            duration time base, one pulse per duration unit
//   InputDirection  live direction while recording
//   MemRdData       RAM read word {dir, count}, one cycle after MemAddr
//   MemAddr         RAM address (write address in record, read in play)
//   MemWrData       RAM write word {dir, count}
//   MemWrite        single-cycle registered write strobe
//   CmdDirection    motor direction during play/rewind, NONE otherwise
//   Busy            record, play or rewind in progress
//   Done            replay finished; held until Mode returns to 0
//   Full            RAM filled during the last recording (sticky)
//   Length          number of stored segments (2^ADDR_W when full)
module route_sequencer
  import route_pkg::*;
#(
  parameter int DIR_W  = 3,
  parameter int CNT_W  = 14,
  parameter int ADDR_W = 10
) (
  input  logic                    Clock,
  input  logic                    Reset,
  input  logic [1:0]              Mode,
  input  logic                    Tick,
  input  logic [DIR_W-1:0]        InputDirection,
  input  logic [DIR_W+CNT_W-1:0]  MemRdData,
  output logic [ADDR_W-1:0]       MemAddr,
  output logic [DIR_W+CNT_W-1:0]  MemWrData,
  output logic                    MemWrite,
  output logic [DIR_W-1:0]        CmdDirection,
  output logic                    Busy,
  output logic                    Done,
  output logic                    Full,
  output logic [ADDR_W:0]         Length
);

  localparam int WORD_W = DIR_W + CNT_W;
  localparam int LEN_W  = ADDR_W + 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  logic [2:0]        state_q,      state_d;
  logic              fetch_ph_q,   fetch_ph_d;    // 0: address out, 1: data in
  logic              rewind_q,     rewind_d;
  logic              seg_active_q, seg_active_d;  // a segment direction is being driven
  logic [DIR_W-1:0]  held_dir_q,   held_dir_d;
  logic [DIR_W-1:0]  dir_q,        dir_d;
  logic [ADDR_W-1:0] wr_ptr_q,     wr_ptr_d;
  logic [ADDR_W-1:0] addr_q,       addr_d;
  logic              we_q,         we_d;
  logic [WORD_W-1:0] wdata_q,      wdata_d;
  logic              full_q,       full_d;
  logic [LEN_W-1:0]  length_q,     length_d;

  logic              cnt_load;
  logic [CNT_W-1:0]  cnt_load_val;
  logic              cnt_inc;
  logic              cnt_dec;
  logic [CNT_W-1:0]  cnt_count;
  logic              cnt_zero;
  logic              cnt_sat;

  logic              wr_req;
  logic [WORD_W-1:0] wr_word;
  logic              adv_req;

  logic [DIR_W-1:0]  rd_dir;
  logic [CNT_W-1:0]  rd_cnt;
  logic [ADDR_W-1:0] last_idx;
  logic              at_last;
  logic              mode_match;
  logic              cmd_active;
  logic [DIR_W-1:0]  play_dir;

  // One counter serves as SegCnt while recording and Remaining while replaying.
  seg_counter #(
    .CNT_W (CNT_W)
  ) u_seg_counter (
    .Clock    (Clock),
    .Reset    (Reset),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .inc      (cnt_inc),
    .dec      (cnt_dec),
    .count    (cnt_count),
    .zero     (cnt_zero),
    .sat      (cnt_sat)
  );

  assign rd_dir     = MemRdData[WORD_W-1:CNT_W];
  assign rd_cnt     = MemRdData[CNT_W-1:0];
  assign last_idx   = ADDR_W'(length_q - LEN_W'(1));
  assign at_last    = rewind_q ? (addr_q == '0) : (addr_q == last_idx);
  assign mode_match = (Mode == (rewind_q ? MODE_REW : MODE_PLAY));

  // The previous direction keeps driving the motors while the next segment
  // is fetched, so consecutive segments join without a NONE gap.
  assign cmd_active = (state_q == ST_RUN) || ((state_q == ST_FETCH) && seg_active_q);
  assign play_dir   = rewind_q ? DIR_W'(inv_dir(32'(dir_q))) : dir_q;

  always_comb begin
    state_d      = state_q;
    fetch_ph_d   = fetch_ph_q;
    rewind_d     = rewind_q;
    seg_active_d = seg_active_q;
    held_dir_d   = held_dir_q;
    dir_d        = dir_q;
    wr_ptr_d     = wr_ptr_q;
    addr_d       = addr_q;
    we_d         = 1'b0;
    wdata_d      = wdata_q;
    full_d       = full_q;
    length_d     = length_q;
    cnt_load     = 1'b0;
    cnt_load_val = '0;
    cnt_inc      = 1'b0;
    cnt_dec      = 1'b0;
    wr_req       = 1'b0;
    wr_word      = '0;
    adv_req      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        seg_active_d = 1'b0;
        fetch_ph_d   = 1'b0;
        if (Mode == MODE_REC) begin
          state_d      = ST_REC;
          wr_ptr_d     = '0;
          full_d       = 1'b0;
          held_dir_d   = InputDirection;
          cnt_load     = 1'b1;
          cnt_load_val = '0;
        end else if (Mode == MODE_PLAY || Mode == MODE_REW) begin
          rewind_d = (Mode == MODE_REW);
          if (length_q == '0) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_FETCH;
            addr_d  = (Mode == MODE_REW) ? last_idx : '0;
          end
        end
      end

      ST_REC: begin
        if (Mode != MODE_REC) begin
          state_d = ST_FLUSH;
        end else if (InputDirection != held_dir_q) begin
          // A tick coinciding with the change belongs to the new segment.
          wr_req       = 1'b1;
          wr_word      = {held_dir_q, cnt_count};
          held_dir_d   = InputDirection;
          cnt_load     = 1'b1;
          cnt_load_val = Tick ? CNT_W'(1) : '0;
        end else if (Tick) begin
          if (cnt_sat) begin
            // Long straight runs are split into max-length segments.
            wr_req       = 1'b1;
            wr_word      = {held_dir_q, cnt_count};
            cnt_load     = 1'b1;
            cnt_load_val = CNT_W'(1);
          end else begin
            cnt_inc = 1'b1;
          end
        end
      end

      ST_FLUSH: begin
        state_d  = ST_IDLE;
        wr_req   = !cnt_zero;
        wr_word  = {held_dir_q, cnt_count};
        // Once full, the pointer parks on the last slot, so the slot it
        // points at is already occupied and counts toward Length.
        length_d = {1'b0, wr_ptr_q} + LEN_W'(full_q) + LEN_W'(!cnt_zero && !full_q);
      end

      ST_FETCH: begin
        if (!mode_match) begin
          state_d      = ST_IDLE;
          seg_active_d = 1'b0;
        end else if (!fetch_ph_q) begin
          fetch_ph_d = 1'b1;
        end else if (rd_cnt == '0) begin
          adv_req = 1'b1;
        end else begin
          dir_d        = rd_dir;
          cnt_load     = 1'b1;
          cnt_load_val = rd_cnt;
          seg_active_d = 1'b1;
          state_d      = ST_RUN;
        end
      end

      ST_RUN: begin
        if (!mode_match) begin
          state_d      = ST_IDLE;
          seg_active_d = 1'b0;
        end else if (Tick) begin
          cnt_dec = 1'b1;
          if (cnt_count == CNT_W'(1)) begin
            adv_req = 1'b1;
          end
        end
      end

      ST_DONE: begin
        seg_active_d = 1'b0;
        if (Mode == MODE_IDLE) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Shared RAM write path: once the last slot is written, further words are dropped.
    if (wr_req && !full_q) begin
      we_d    = 1'b1;
      addr_d  = wr_ptr_q;
      wdata_d = wr_word;
      if (wr_ptr_q == LAST_ADDR) begin
        full_d = 1'b1;
      end else begin
        wr_ptr_d = wr_ptr_q + ADDR_W'(1);
      end
    end

    // Segment finished (or skipped): step to the next one or stop.
    if (adv_req) begin
      if (at_last) begin
        state_d = ST_DONE;
      end else begin
        addr_d     = rewind_q ? (addr_q - ADDR_W'(1)) : (addr_q + ADDR_W'(1));
        state_d    = ST_FETCH;
        fetch_ph_d = 1'b0;
      end
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q      <= ST_IDLE;
      fetch_ph_q   <= 1'b0;
      rewind_q     <= 1'b0;
      seg_active_q <= 1'b0;
      held_dir_q   <= '0;
      dir_q        <= '0;
      wr_ptr_q     <= '0;
      addr_q       <= '0;
      we_q         <= 1'b0;
      wdata_q      <= '0;
      full_q       <= 1'b0;
      length_q     <= '0;
    end else begin
      state_q      <= state_d;
      fetch_ph_q   <= fetch_ph_d;
      rewind_q     <= rewind_d;
      seg_active_q <= seg_active_d;
      held_dir_q   <= held_dir_d;
      dir_q        <= dir_d;
      wr_ptr_q     <= wr_ptr_d;
      addr_q       <= addr_d;
      we_q         <= we_d;
      wdata_q      <= wdata_d;
      full_q       <= full_d;
      length_q     <= length_d;
    end
  end

  assign MemAddr      = addr_q;
  assign MemWrData    = wdata_q;
  assign MemWrite     = we_q;
  assign CmdDirection = cmd_active ? play_dir : DIR_W'(DIR_NONE);
  assign Busy         = (state_q == ST_REC) || (state_q == ST_FLUSH) ||
                        (state_q == ST_FETCH) || (state_q == ST_RUN);
  assign Done         = (state_q == ST_DONE);
  assign Full         = full_q;
  assign Length       = length_q;

endmodule

// File: tb/tb_route_sequencer.sv
// Bench for route_sequencer with a small RAM (ADDR_W=2) and short counter
// (CNT_W=4) so that saturation and RAM-full behaviour are reached quickly.
module tb_route_sequencer;
  import route_pkg::*;

  localparam int DIR_W  = 3;
  localparam int CNT_W  = 4;
  localparam int ADDR_W = 2;
  localparam int WORD_W = DIR_W + CNT_W;
  localparam int DEPTH  = 1 << ADDR_W;
  localparam int CMAX   = (1 << CNT_W) - 1;

  localparam logic [2:0] F = 3'd1;
  localparam logic [2:0] B = 3'd2;
  localparam logic [2:0] L = 3'd3;
  localparam logic [2:0] R = 3'd4;

  logic               Clock = 1'b0;
  logic               Reset;
  logic [1:0]         Mode;
  logic               Tick;
  logic [DIR_W-1:0]   InputDirection;
  logic [WORD_W-1:0]  MemRdData;
  logic [ADDR_W-1:0]  MemAddr;
  logic [WORD_W-1:0]  MemWrData;
  logic               MemWrite;
  logic [DIR_W-1:0]   CmdDirection;
  logic               Busy;
  logic               Done;
  logic               Full;
  logic [ADDR_W:0]    Length;

  route_sequencer #(.DIR_W(DIR_W), .CNT_W(CNT_W), .ADDR_W(ADDR_W)) dut (
    .Clock          (Clock),
    .Reset          (Reset),
    .Mode           (Mode),
    .Tick           (Tick),
    .InputDirection (InputDirection),
    .MemRdData      (MemRdData),
    .MemAddr        (MemAddr),
    .MemWrData      (MemWrData),
    .MemWrite       (MemWrite),
    .CmdDirection   (CmdDirection),
    .Busy           (Busy),
    .Done           (Done),
    .Full           (Full),
    .Length         (Length)
  );

  always #5 Clock = ~Clock;

  // External synchronous RAM, read data one cycle after the address.
  logic [WORD_W-1:0] mem [DEPTH];
  always @(posedge Clock) begin
    if (MemWrite) mem[MemAddr] <= MemWrData;
    MemRdData <= mem[MemAddr];
  end

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  function automatic logic [2:0] inv_tb(input logic [2:0] d);
    case (d)
      F: return B;
      B: return F;
      L: return R;
      R: return L;
      default: return d;
    endcase
  endfunction

  // Scoreboard queues.
  logic [ADDR_W+WORD_W-1:0] exp_wr_q[$];
  logic [DIR_W-1:0]         exp_cmd_q[$];

  // Reference model of the stored route.
  logic [DIR_W-1:0] seg_dir[$];
  int               seg_cnt[$];
  int               m_len = 0;
  int               m_ptr;
  bit               m_full = 1'b0;
  bit               m_wrote;
  logic [DIR_W-1:0] m_held;
  int               m_cnt;

  function automatic void m_write(input logic [DIR_W-1:0] d, input int c);
    if (!m_full) begin
      exp_wr_q.push_back({ADDR_W'(m_ptr), d, CNT_W'(c)});
      seg_dir.push_back(d);
      seg_cnt.push_back(c);
      m_wrote = 1'b1;
      if (m_ptr == DEPTH - 1) m_full = 1'b1;
      else m_ptr++;
    end
  endfunction

  // Monitor: compares every RAM write and every counted tick during replay.
  logic [ADDR_W+WORD_W-1:0] mon_wr;
  logic [DIR_W-1:0]         mon_cmd;
  always @(negedge Clock) begin
    if (!Reset) begin
      if (MemWrite) begin
        if (exp_wr_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL wr_unexpected actual=addr %0d word %0d required=no write", MemAddr, MemWrData);
        end else begin
          mon_wr = exp_wr_q.pop_front();
          check("wr_addr", MemAddr, mon_wr[ADDR_W+WORD_W-1:WORD_W]);
          check("wr_word", MemWrData, mon_wr[WORD_W-1:0]);
        end
      end
      if (Tick && CmdDirection != 0) begin
        if (exp_cmd_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL cmd_unexpected actual=%0d required=no command", CmdDirection);
        end else begin
          mon_cmd = exp_cmd_q.pop_front();
          check("cmd_dir", CmdDirection, mon_cmd);
        end
      end
    end
  end

  // Recording stimulus, one entry per clock cycle.
  logic [DIR_W-1:0] st_dir[$];
  bit               st_tick[$];
  logic [DIR_W-1:0] st_d0;

  task automatic add_steps(input logic [DIR_W-1:0] d, input bit t, input int n);
    for (int i = 0; i < n; i++) begin
      st_dir.push_back(d);
      st_tick.push_back(t);
    end
  endtask

  task automatic do_record();
    seg_dir.delete();
    seg_cnt.delete();
    m_ptr = 0;
    m_full = 1'b0;
    m_cnt = 0;
    InputDirection = st_d0;
    Tick = 1'b0;
    Mode = MODE_REC;
    @(posedge Clock);
    m_held = st_d0;
    #1;
    for (int i = 0; i < st_dir.size(); i++) begin
      InputDirection = st_dir[i];
      Tick = st_tick[i];
      @(posedge Clock);
      m_wrote = 1'b0;
      if (st_dir[i] != m_held) begin
        m_write(m_held, m_cnt);
        m_held = st_dir[i];
        m_cnt = st_tick[i] ? 1 : 0;
      end else if (st_tick[i]) begin
        if (m_cnt == CMAX) begin
          m_write(m_held, CMAX);
          m_cnt = 1;
        end else begin
          m_cnt++;
        end
      end
      #1;
      check("wr_latency", MemWrite, m_wrote);
      check("rec_busy", Busy, 1);
    end
    Tick = 1'b0;
    Mode = MODE_IDLE;
    @(posedge Clock);
    #1;
    check("flush_enter_no_wr", MemWrite, 0);
    m_wrote = 1'b0;
    if (m_cnt != 0) m_write(m_held, m_cnt);
    @(posedge Clock);
    #1;
    check("flush_wr", MemWrite, m_wrote);
    m_len = seg_dir.size();
    check("rec_length", Length, m_len);
    check("rec_full", Full, m_full);
    check("rec_idle", Busy, 0);
    @(posedge Clock);
    #1;
    check("wr_drained", exp_wr_q.size(), 0);
    st_dir.delete();
    st_tick.delete();
  endtask

  task automatic do_play(input logic [1:0] md);
    int guard;
    exp_cmd_q.delete();
    if (md == MODE_PLAY) begin
      for (int i = 0; i < seg_dir.size(); i++)
        repeat (seg_cnt[i]) exp_cmd_q.push_back(seg_dir[i]);
    end else begin
      for (int i = seg_dir.size() - 1; i >= 0; i--)
        repeat (seg_cnt[i]) exp_cmd_q.push_back(inv_tb(seg_dir[i]));
    end
    Mode = md;
    @(posedge Clock);
    #1;
    if (m_len == 0) begin
      check("empty_done", Done, 1);
      check("empty_cmd", CmdDirection, 0);
    end else begin
      check("start_addr", MemAddr, (md == MODE_PLAY) ? 0 : m_len - 1);
      check("start_busy", Busy, 1);
      @(posedge Clock);
      #1;
      check("start_cmd_gap", CmdDirection, 0);
      @(posedge Clock);
      #1;
      check("start_cmd", CmdDirection, exp_cmd_q[0]);
      guard = 0;
      while (!Done && guard < 300) begin
        Tick = 1'b1;
        @(posedge Clock);
        #1;
        Tick = 1'b0;
        for (int k = 0; k < 4; k++) begin
          if (!Done) check("cmd_held", (CmdDirection != 0) ? 1 : 0, 1);
          @(posedge Clock);
          #1;
        end
        guard++;
      end
      check("play_done", Done, 1);
      check("done_cmd", CmdDirection, 0);
    end
    check("cmd_drained", exp_cmd_q.size(), 0);
    check("full_sticky", Full, m_full);
    check("len_kept", Length, m_len);
    Mode = MODE_IDLE;
    @(posedge Clock);
    #1;
    check("done_release", Done, 0);
  endtask

  task automatic do_abort();
    int guard;
    exp_cmd_q.delete();
    exp_cmd_q.push_back(seg_dir[0]);
    Mode = MODE_PLAY;
    guard = 0;
    while (CmdDirection == 0 && guard < 20) begin
      @(posedge Clock);
      #1;
      guard++;
    end
    check("abort_started", (CmdDirection != 0) ? 1 : 0, 1);
    Tick = 1'b1;
    @(posedge Clock);
    #1;
    Tick = 1'b0;
    Mode = MODE_IDLE;
    @(posedge Clock);
    #1;
    check("abort_cmd", CmdDirection, 0);
    check("abort_busy", Busy, 0);
    check("abort_length", Length, m_len);
    check("abort_drained", exp_cmd_q.size(), 0);
    exp_cmd_q.delete();
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [DIR_W-1:0] cur;
    bit t;
    int n;
    Reset = 1'b1;
    Mode = MODE_IDLE;
    Tick = 1'b0;
    InputDirection = '0;
    repeat (3) @(posedge Clock);
    #1;
    check("rst_addr", MemAddr, 0);
    check("rst_we", MemWrite, 0);
    check("rst_wdata", MemWrData, 0);
    check("rst_cmd", CmdDirection, 0);
    check("rst_busy", Busy, 0);
    check("rst_done", Done, 0);
    check("rst_full", Full, 0);
    check("rst_length", Length, 0);
    Reset = 1'b0;
    @(posedge Clock);
    #1;

    // FWD for 5 ticks, then LEFT for 3 ticks.
    st_d0 = F;
    for (int i = 0; i < 5; i++) begin add_steps(F, 1, 1); add_steps(F, 0, 1); end
    add_steps(L, 0, 1);
    for (int i = 0; i < 3; i++) begin add_steps(L, 1, 1); add_steps(L, 0, 1); end
    do_record();
    check("route_len", Length, 2);
    check("route_ram0", mem[0], (1 << CNT_W) | 5);
    check("route_ram1", mem[1], (3 << CNT_W) | 3);
    do_play(MODE_PLAY);
    do_play(MODE_REW);
    do_abort();

    // 20 ticks in one direction split at the counter maximum.
    st_d0 = F;
    add_steps(F, 1, 20);
    do_record();
    @(posedge Clock);
    #1;
    check("sat_ram0", mem[0], (1 << CNT_W) | 15);
    check("sat_ram1", mem[1], (1 << CNT_W) | 5);
    do_play(MODE_PLAY);

    // Six direction changes into a four-entry RAM.
    st_d0 = F;
    add_steps(F, 1, 1);
    add_steps(L, 1, 1);
    add_steps(R, 1, 1);
    add_steps(B, 1, 1);
    add_steps(F, 1, 1);
    add_steps(L, 1, 1);
    add_steps(R, 1, 1);
    do_record();
    check("full_flag", Full, 1);
    check("full_len", Length, 4);
    do_play(MODE_REW);

    // Empty recording: no ticks at all.
    st_d0 = L;
    add_steps(L, 0, 3);
    do_record();
    check("empty_len", Length, 0);
    do_play(MODE_PLAY);
    do_play(MODE_REW);

    // Random routes.
    for (int it = 0; it < 6; it++) begin
      cur = 3'($urandom_range(1, 4));
      st_d0 = cur;
      add_steps(cur, 1, 1);
      n = $urandom_range(8, 40);
      for (int s = 0; s < n; s++) begin
        t = ($urandom_range(0, 3) != 0);
        if (t && $urandom_range(0, 4) == 0) cur = 3'($urandom_range(1, 4));
        add_steps(cur, t, 1);
      end
      do_record();
      do_play(MODE_PLAY);
      do_play(MODE_REW);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
